// File: rtl/pll_freq_meter_if.sv
// Bus bundle for the PLL frequency meter: start/lock/tap inputs and result outputs.
`timescale 1ns/1ps
interface pll_freq_meter_if #(
  parameter int N_CH  = 6,
  parameter int CNT_W = 16
);
  logic             I_START;
  logic             I_LOCKED;
  logic [N_CH-1:0]  I_SIG;
  logic [2:0]       I_SEL;
  logic             O_BUSY;
  logic             O_DONE;
  logic             O_ABORT;
  logic [N_CH-1:0]  O_ALIVE;
  logic [CNT_W-1:0] O_COUNT;

  modport master (
    output I_START, I_LOCKED, I_SIG, I_SEL,
    input  O_BUSY, O_DONE, O_ABORT, O_ALIVE, O_COUNT
  );

  modport slave (
    input  I_START, I_LOCKED, I_SIG, I_SEL,
    output O_BUSY, O_DONE, O_ABORT, O_ALIVE, O_COUNT
  );
endinterface

// File: rtl/pll_freq_meter.sv
// PLL frequency meter: counts rising edges of asynchronous counter taps over a
// fixed gate window of CLK cycles, gated by the synchronised PLL lock.
`timescale 1ns/1ps
module pll_freq_meter #(
  parameter int N_CH        = 6,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 4194304,
  parameter int MIN_EDGES   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  pll_freq_meter_if.slave    bus
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, MEASURE, DONE} state_t;

  state_t state, next_state;

  logic [N_CH-1:0]   sig_meta, sig_sync, sig_prev;
  logic [N_CH-1:0]   rise;
  logic              lock_meta, lock_sync;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  cnt [N_CH];
  logic [CNT_W-1:0]  res [N_CH];
  logic [N_CH-1:0]   alive;
  logic              abort;
  logic [CNT_W-1:0]  count_q, count_nxt;

  logic enter_wait, clear, count_en, set_abort, latch;

  assign rise = sig_sync & ~sig_prev;

  // Two-flop synchronisers for taps and lock, plus one-flop edge history for taps
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sig_meta  <= '0;
      sig_sync  <= '0;
      sig_prev  <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sig_meta  <= bus.I_SIG;
      sig_sync  <= sig_meta;
      sig_prev  <= sig_sync;
      lock_meta <= bus.I_LOCKED;
      lock_sync <= lock_meta;
    end
  end

  // Measurement state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control; lock loss wins over the last gate cycle
  always_comb begin
    next_state = state;
    enter_wait = 1'b0;
    clear      = 1'b0;
    count_en   = 1'b0;
    set_abort  = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.I_START) begin
          next_state = WAIT_LOCK;
          enter_wait = 1'b1;
        end
      end
      WAIT_LOCK: begin
        clear = 1'b1;
        if (lock_sync) next_state = MEASURE;
      end
      MEASURE: begin
        if (!lock_sync) begin
          set_abort  = 1'b1;
          next_state = DONE;
        end else begin
          count_en = 1'b1;
          if (gate_cnt == GATE_LAST) next_state = DONE;
        end
      end
      DONE: begin
        latch      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Gate counter and saturating per-channel edge counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gate_cnt <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (clear) begin
      gate_cnt <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (count_en) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sticky abort flag, cleared when a new measurement is requested
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         abort <= 1'b0;
    else if (enter_wait) abort <= 1'b0;
    else if (set_abort)  abort <= 1'b1;
  end

  // Result registers and alive flags update only in the DONE cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) res[i] <= '0;
      alive <= '0;
    end else if (latch) begin
      for (int i = 0; i < N_CH; i++) begin
        res[i]   <= cnt[i];
        alive[i] <= !abort && (cnt[i] >= CNT_W'(MIN_EDGES));
      end
    end
  end

  // Channel select mux; selects beyond the channel count read as zero
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.I_SEL == 3'(i)) count_nxt = res[i];
    end
  end

  // Registered count output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) count_q <= '0;
    else        count_q <= count_nxt;
  end

  assign bus.O_BUSY  = (state == WAIT_LOCK) || (state == MEASURE);
  assign bus.O_DONE  = (state == DONE);
  assign bus.O_ABORT = abort;
  assign bus.O_ALIVE = alive;
  assign bus.O_COUNT = count_q;

endmodule

// File: doc/pll_freq_meter.md
Name: pll_freq_meter

Overview:
- Receiving end for the PLL clock-test counter taps: samples up to N_CH asynchronous toggle signals (counter MSBs clocked by PLL outputs) in the single CLK domain.
- Counts rising edges of each tap over a fixed gate window of CLK cycles.
- Reports per-channel edge counts and alive flags, so on-board or simulation checks can confirm every PLL output runs at the expected ratio.
- Sits beside the PLL test top, fed by its LOCKED output and its counter taps.

Parameters:
- N_CH, 6, number of measured channels.
- CNT_W, 16, per-channel edge counter width; counters saturate.
- GATE_CYCLES, 4194304, measurement window length in CLK cycles (>=4).
- MIN_EDGES, 2, minimum edges for a channel's alive flag to be set.

Ports:
- CLK  input  1  reference clock; sole clock domain.
- RST_N  input  1  asynchronous, active-low reset.
- I_START  input  1  single-cycle request to begin a measurement.
- I_LOCKED  input  1  PLL lock status; asynchronous, synchronised internally.
- I_SIG  input  N_CH  asynchronous toggle taps, one per channel.
- I_SEL  input  3  channel select for O_COUNT.
- O_BUSY  output  1  high in WAIT_LOCK or MEASURE.
- O_DONE  output  1  one-cycle pulse when a measurement ends, completed or aborted.
- O_ABORT  output  1  sticky; set when lock is lost during MEASURE.
- O_ALIVE  output  N_CH  per channel: last count >= MIN_EDGES.
- O_COUNT  output  CNT_W  registered count of channel I_SEL.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low. While RST_N=0, all flops clear: O_BUSY=0, O_DONE=0, O_ABORT=0, O_ALIVE=0, O_COUNT=0, all counters and synchronisers=0, state=IDLE.
- Input synchronisation: each I_SIG bit and I_LOCKED pass through a 2-flop synchroniser. Each synchronised I_SIG bit then feeds a 1-flop edge detector. A rise on I_SIG is counted at the earliest 3 CLK cycles after it is captured.
- IDLE:
  - I_START=1 moves to WAIT_LOCK.
  - I_START is ignored in every other state.
- WAIT_LOCK:
  - Clears all channel counters and the gate counter.
  - Moves to MEASURE on the first cycle in which synchronised lock=1.
  - Waits indefinitely; there is no timeout.
- MEASURE:
  - The gate counter runs 0..GATE_CYCLES-1. A detected rising edge increments its channel counter in any MEASURE cycle.
  - Channel counters saturate at 2^CNT_W-1 and never wrap.
  - When the gate counter reaches GATE_CYCLES-1, edges detected in that cycle still count. The next state is DONE.
  - If synchronised lock=0 in any MEASURE cycle, go to DONE with O_ABORT set. Edges detected in that cycle are not counted.
- DONE (exactly one cycle):
  - O_DONE=1.
  - Final counts latch into result registers.
  - O_ALIVE[i] updates to (count[i] >= MIN_EDGES); on abort, O_ALIVE updates to 0.
  - Then return to IDLE.
- O_ABORT: cleared on entry to WAIT_LOCK.
- Results: O_ALIVE and the result registers hold their values until the next DONE.
- O_COUNT: registered mux of the result registers.
  - 1-cycle latency from I_SEL.
  - I_SEL >= N_CH gives 0.
- Simultaneous events: an I_START in the DONE cycle is ignored.
- Reset mid-measurement: an immediate return to IDLE with all results cleared. No O_DONE pulse.
- Gate counter width: clog2(GATE_CYCLES).

Test Plan:
- Reset then idle: hold RST_N=0 for 5 cycles with I_SIG toggling, then release, no start. Required: all outputs 0 throughout, O_BUSY=0.
- Nominal count: GATE_CYCLES=1000, I_LOCKED=1. Channel i toggles every 10*(i+1) CLK cycles. Pulse I_START. Required:
  - O_BUSY for about 1001 cycles, then one O_DONE pulse.
  - O_COUNT for I_SEL=0..5 reads 50, 25, 16-17, 12-13, 10, 8-9 (±1).
  - O_ALIVE=6'b111111.
- Dead channel: as the nominal test but I_SIG[3] held at 0. Required: count[3]=0, O_ALIVE=6'b110111, all other counts as in the nominal test.
- Lock gating and abort:
  - Pulse I_START with I_LOCKED=0 for 200 cycles. Required: O_BUSY=1, no counting.
  - Raise I_LOCKED, then drop it 300 cycles into MEASURE. Required: O_DONE pulse, O_ABORT=1, O_ALIVE=0.
  - A later successful run clears O_ABORT.
- Saturation: CNT_W=4, GATE_CYCLES=1000, I_SIG[0] toggling every cycle. Required: count[0]=15, not wrapped.
- Mid-run reset: assert RST_N=0 at gate cycle 500 of a nominal run. Required: immediate clear of all outputs, no O_DONE, state IDLE. A restart then produces the nominal-test results.
